// File: rtl/mult_pkg.sv
// Shared types and constants for the pipelined RISC-V M-extension multiplier.
// Packet widths are fixed here; the top-level width parameters must match them.
package mult_pkg;

   localparam int MULT_XLEN    = 32;
   localparam int MULT_PRF_LEN = 6;
   localparam int MULT_ROB_LEN = 5;
   localparam int MULT_STAGES  = 4;
   localparam int MULT_CHUNK   = 2 * MULT_XLEN / MULT_STAGES;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } MUL_FUNC;

   typedef struct packed {
      logic                      valid;
      MUL_FUNC                   func;
      logic                      neg;
      logic [MULT_PRF_LEN-1:0]   prf_idx;
      logic [MULT_ROB_LEN-1:0]   rob_idx;
      logic [2*MULT_XLEN-1:0]    mcand;
      logic [2*MULT_XLEN-1:0]    mplier;
      logic [2*MULT_XLEN-1:0]    sum;
   } MULT_PIPE_PACKET;

   // Multiplier bits retired per stage for a given width and depth.
   function automatic int mult_chunk(input int xlen, input int stages);
      return 2 * xlen / stages;
   endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One registered multiplier stage: folds the low CHUNK bits of the multiplier
// into the partial sum, then advances the multiplicand/multiplier windows.
module mult_pipe_stage
   import mult_pkg::*;
#(
   parameter int CHUNK = MULT_CHUNK
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            hold,
   input  logic            kill,
   input  MULT_PIPE_PACKET in_pkt,
   output MULT_PIPE_PACKET out_pkt
);

   localparam int W = 2 * MULT_XLEN;

   MULT_PIPE_PACKET pkt_d;
   MULT_PIPE_PACKET pkt_q;
   logic [W-1:0]    partial;

   // Kill wins over hold so a squash also drains a stalled pipe.
   always_comb begin
      partial = in_pkt.mcand * W'(in_pkt.mplier[CHUNK-1:0]);
      pkt_d   = pkt_q;
      if (kill) begin
         pkt_d.valid = 1'b0;
      end else if (!hold) begin
         pkt_d        = in_pkt;
         pkt_d.sum    = in_pkt.sum + partial;
         pkt_d.mcand  = in_pkt.mcand << CHUNK;
         pkt_d.mplier = in_pkt.mplier >> CHUNK;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pkt_q <= '0;
      end else begin
         pkt_q <= pkt_d;
      end
   end

   assign out_pkt = pkt_q;

endmodule

// File: rtl/mult_pipe_cdb.sv
// Fully pipelined MUL/MULH/MULHSU/MULHU unit between the multiply RS and the CDB.
// Global stall on CDB backpressure; flush drops every in-flight op.
module mult_pipe_cdb
   import mult_pkg::*;
#(
   parameter int XLEN    = MULT_XLEN,
   parameter int STAGES  = MULT_STAGES,
   parameter int PRF_LEN = MULT_PRF_LEN,
   parameter int ROB_LEN = MULT_ROB_LEN
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_opa,
   input  logic [XLEN-1:0]    in_opb,
   input  logic [1:0]         in_func,
   input  logic [PRF_LEN-1:0] in_prf_idx,
   input  logic [ROB_LEN-1:0] in_rob_idx,
   input  logic               flush,
   output logic               out_valid,
   output logic [XLEN-1:0]    out_value,
   output logic [PRF_LEN-1:0] out_prf_idx,
   output logic [ROB_LEN-1:0] out_rob_idx,
   input  logic               out_grant
);

   localparam int CHUNK = mult_chunk(XLEN, STAGES);

   MUL_FUNC           func;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              stall;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   result;
   MULT_PIPE_PACKET   front_pkt;
   MULT_PIPE_PACKET   stage_in  [STAGES];
   MULT_PIPE_PACKET   stage_out [STAGES];

   assign stall    = stage_out[STAGES-1].valid & ~out_grant;
   assign in_ready = ~stall;

   // Magnitudes of the most negative value (2^(XLEN-1)) still fit unsigned.
   always_comb begin
      func      = MUL_FUNC'(in_func);
      a_neg     = (func != MULHU) & in_opa[XLEN-1];
      b_neg     = ((func == MUL) | (func == MULH)) & in_opb[XLEN-1];
      a_mag     = a_neg ? -in_opa : in_opa;
      b_mag     = b_neg ? -in_opb : in_opb;
      front_pkt         = '0;
      front_pkt.valid   = in_valid & in_ready;
      front_pkt.func    = func;
      front_pkt.neg     = a_neg ^ b_neg;
      front_pkt.prf_idx = in_prf_idx;
      front_pkt.rob_idx = in_rob_idx;
      front_pkt.mcand   = {{XLEN{1'b0}}, a_mag};
      front_pkt.mplier  = {{XLEN{1'b0}}, b_mag};
      front_pkt.sum     = '0;
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign stage_in[g] = front_pkt;
      end else begin : g_link
         assign stage_in[g] = stage_out[g-1];
      end

      mult_pipe_stage #(
         .CHUNK (CHUNK)
      ) u_stage (
         .clock   (clock),
         .reset_n (reset_n),
         .hold    (stall),
         .kill    (flush),
         .in_pkt  (stage_in[g]),
         .out_pkt (stage_out[g])
      );
   end

   // Tail outputs are forced to zero whenever no valid result is present.
   always_comb begin
      prod        = stage_out[STAGES-1].neg ? -stage_out[STAGES-1].sum : stage_out[STAGES-1].sum;
      result      = (stage_out[STAGES-1].func == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      out_valid   = stage_out[STAGES-1].valid;
      out_value   = '0;
      out_prf_idx = '0;
      out_rob_idx = '0;
      if (out_valid) begin
         out_value   = result;
         out_prf_idx = stage_out[STAGES-1].prf_idx;
         out_rob_idx = stage_out[STAGES-1].rob_idx;
      end
   end

endmodule

// File: tb/tb_mult_pipe_cdb.sv
// Randomised self-checking bench for mult_pipe_cdb against a queue-based
// reference model; also runs STAGES=2 and STAGES=8 copies on the same stimulus.
module tb_mult_pipe_cdb;
   import mult_pkg::*;

   localparam int LAT = 4;

   typedef struct {
      logic [31:0] value;
      logic [5:0]  prf;
      logic [4:0]  rob;
      int          issue;
      int          stall_at;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] in_opa;
   logic [31:0] in_opb;
   logic [1:0]  in_func;
   logic [5:0]  in_prf_idx;
   logic [4:0]  in_rob_idx;
   logic        flush;
   logic        out_grant;

   logic        in_ready, out_valid;
   logic [31:0] out_value;
   logic [5:0]  out_prf_idx;
   logic [4:0]  out_rob_idx;

   logic        in_ready2, out_valid2;
   logic [31:0] out_value2;
   logic [5:0]  out_prf2;
   logic [4:0]  out_rob2;

   logic        in_ready8, out_valid8;
   logic [31:0] out_value8;
   logic [5:0]  out_prf8;
   logic [4:0]  out_rob8;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          stall_total = 0;
   int          sweep_start = 0;
   int          check_count = 0;
   int          error_count = 0;
   logic        hist_v [64];
   logic [42:0] hist_d [64];

   always #5 clock = ~clock;

   mult_pipe_cdb #(.XLEN(32), .STAGES(4), .PRF_LEN(6), .ROB_LEN(5)) u_dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func), .in_prf_idx(in_prf_idx),
      .in_rob_idx(in_rob_idx), .flush(flush), .out_valid(out_valid), .out_value(out_value),
      .out_prf_idx(out_prf_idx), .out_rob_idx(out_rob_idx), .out_grant(out_grant)
   );

   mult_pipe_cdb #(.XLEN(32), .STAGES(2), .PRF_LEN(6), .ROB_LEN(5)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func), .in_prf_idx(in_prf_idx),
      .in_rob_idx(in_rob_idx), .flush(1'b0), .out_valid(out_valid2), .out_value(out_value2),
      .out_prf_idx(out_prf2), .out_rob_idx(out_rob2), .out_grant(1'b1)
   );

   mult_pipe_cdb #(.XLEN(32), .STAGES(8), .PRF_LEN(6), .ROB_LEN(5)) u_dut8 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
      .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func), .in_prf_idx(in_prf_idx),
      .in_rob_idx(in_rob_idx), .flush(1'b0), .out_valid(out_valid8), .out_value(out_value8),
      .out_prf_idx(out_prf8), .out_rob_idx(out_rob8), .out_grant(1'b1)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Architectural result computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_mult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      ub;
      logic [63:0] ua;
      logic [63:0] ubu;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'd0, b});
      ua  = {32'd0, a};
      ubu = {32'd0, b};
      case (f)
         2'd0:    p = 64'(sa * sb);
         2'd1:    p = 64'(sa * sb);
         2'd2:    p = 64'(sa * ub);
         default: p = ua * ubu;
      endcase
      return (f == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   // One cycle: drive inputs at the falling edge, then compare the tail to the model.
   task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [5:0] prf, input logic [4:0] rob,
                                input logic grant, input logic fl);
      exp_t e;
      logic tail_occ;
      @(negedge clock);
      cyc++;
      in_valid   = v;
      in_func    = f;
      in_opa     = a;
      in_opb     = b;
      in_prf_idx = prf;
      in_rob_idx = rob;
      out_grant  = grant;
      flush      = fl;
      #1;
      tail_occ = (exp_q.size() != 0) &&
                 (cyc >= exp_q[0].issue + LAT + (stall_total - exp_q[0].stall_at));
      checkOutput("out_valid", 64'(out_valid), 64'(tail_occ));
      checkOutput("in_ready", 64'(in_ready), 64'(!(tail_occ && !grant)));
      if (tail_occ) begin
         checkOutput("out_value", 64'(out_value), 64'(exp_q[0].value));
         checkOutput("out_tags", 64'({out_prf_idx, out_rob_idx}), 64'({exp_q[0].prf, exp_q[0].rob}));
         if (grant) void'(exp_q.pop_front());
         else stall_total++;
      end else begin
         checkOutput("gated_value", 64'(out_value), 64'd0);
      end
      if (fl) begin
         exp_q.delete();
      end else if (v && !(tail_occ && !grant)) begin
         e.value    = ref_mult(f, a, b);
         e.prf      = prf;
         e.rob      = rob;
         e.issue    = cyc;
         e.stall_at = stall_total;
         exp_q.push_back(e);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 1'b0);
   endtask

   // The STAGES=2/8 copies never stall, so each result is the op issued L cycles ago.
   task automatic checkSweep(input logic v, input logic [42:0] d);
      int   i2;
      int   i8;
      logic e2;
      logic e8;
      i2 = cyc - 2;
      i8 = cyc - 8;
      e2 = (i2 > sweep_start) && hist_v[i2 % 64];
      e8 = (i8 > sweep_start) && hist_v[i8 % 64];
      checkOutput("s2_valid", 64'(out_valid2), 64'(e2));
      checkOutput("s8_valid", 64'(out_valid8), 64'(e8));
      if (e2) checkOutput("s2_data", 64'({out_prf2, out_rob2, out_value2}), 64'(hist_d[i2 % 64]));
      else    checkOutput("s2_gated", 64'(out_value2), 64'd0);
      if (e8) checkOutput("s8_data", 64'({out_prf8, out_rob8, out_value8}), 64'(hist_d[i8 % 64]));
      else    checkOutput("s8_gated", 64'(out_value8), 64'd0);
      checkOutput("s_ready", 64'({in_ready2, in_ready8}), 64'd3);
      hist_v[cyc % 64] = v;
      hist_d[cyc % 64] = d;
   endtask

   task automatic doReset();
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_opa     = '0;
      in_opb     = '0;
      in_func    = '0;
      in_prf_idx = '0;
      in_rob_idx = '0;
      flush      = 1'b0;
      out_grant  = 1'b1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      exp_q.delete();
      stall_total = 0;
   endtask

   initial begin
      logic        v;
      logic [1:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  prf;
      logic [4:0]  rob;

      doReset();
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_value", 64'(out_value), 64'd0);
      checkOutput("reset_tags", 64'({out_prf_idx, out_rob_idx}), 64'd0);
      checkOutput("reset_ready", 64'(in_ready), 64'd1);

      $display("[TB] test 1: single MUL 7 * -3");
      applyStimulus(1'b1, MUL, 32'd7, 32'hFFFF_FFFD, 6'd1, 5'd5, 1'b1, 1'b0);
      idleCycles(6);

      $display("[TB] test 2: back-to-back high/low products");
      applyStimulus(1'b1, MULH,   32'h8000_0000, 32'h8000_0000, 6'd2, 5'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 5'd2, 1'b1, 1'b0);
      applyStimulus(1'b1, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 5'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, MUL,    32'h0001_0000, 32'h0001_0000, 6'd5, 5'd4, 1'b1, 1'b0);
      idleCycles(6);

      $display("[TB] test 3: CDB backpressure");
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 2'(i), rand_operand(), rand_operand(), 6'(10 + i), 5'(10 + i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, MUL, rand_operand(), rand_operand(), 6'(20 + i), 5'(20 + i), 1'b0, 1'b0);
      idleCycles(8);

      $display("[TB] test 4: flush with ops in flight");
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, MULH, rand_operand(), rand_operand(), 6'(30 + i), 5'(30 + i), 1'b1, 1'b0);
      applyStimulus(1'b1, MUL, 32'd9, 32'd9, 6'd33, 5'd3, 1'b1, 1'b1);
      applyStimulus(1'b1, MUL, 32'd6, 32'hFFFF_FFF9, 6'd34, 5'd4, 1'b1, 1'b0);
      idleCycles(8);

      $display("[TB] test 5: asynchronous reset mid-operation");
      applyStimulus(1'b1, MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 6'd40, 5'd10, 1'b1, 1'b0);
      applyStimulus(1'b0, MUL, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, MUL, 32'd3, 32'd5, 6'd41, 5'd11, 1'b1, 1'b0);
      applyStimulus(1'b0, MUL, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, MUL, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("async_rst_value", 64'(out_value), 64'd0);
      checkOutput("async_rst_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      checkOutput("rst_hold_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      exp_q.delete();
      stall_total = 0;
      idleCycles(2 * LAT);

      $display("[TB] test 6: random sweep over STAGES=4, 2 and 8");
      doReset();
      sweep_start = cyc;
      for (int i = 0; i < 300; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         f   = 2'($urandom_range(0, 3));
         a   = rand_operand();
         b   = rand_operand();
         prf = 6'($urandom());
         rob = 5'($urandom());
         applyStimulus(v, f, a, b, prf, rob, ($urandom_range(0, 5) != 0), ($urandom_range(0, 49) == 0));
         checkSweep(v, {prf, rob, ref_mult(f, a, b)});
      end
      idleCycles(10);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
